// File: rtl/pwm_pkg.sv
// Shared definitions for the LED fade sequencer: FSM state encodings and
// the full-scale duty helper.
package pwm_pkg;

  localparam int unsigned STATE_W = 3;

  // Fade FSM states; the encoding is visible on the debug state port.
  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } fade_state_e;

  // Full-scale duty for a counter of cnt_w bits (one full period high).
  function automatic int unsigned dmax(input int unsigned cnt_w);
    return 32'd1 << cnt_w;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM period counter with a registered end-of-period pulse and
// the compare of the counter against a runtime duty.
//   clk, rst   : clock, asynchronous active-high reset
//   duty       : active duty, 0..2^CNT_W (2^CNT_W = always high)
//   pwm_out    : cnt < duty, combinational from registers
//   period_end : high for the single cycle in which cnt == 2^CNT_W-1
module pwm_core #(
  parameter int unsigned CNT_W = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [CNT_W:0] duty,
  output logic           pwm_out,
  output logic           period_end
);

  // Value one below terminal count, so period_end lines up with cnt == max.
  localparam logic [CNT_W-1:0] CNT_PRE = {{(CNT_W-1){1'b1}}, 1'b0};

  logic [CNT_W-1:0] cnt;

  // Period counter and aligned end-of-period flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt + CNT_W'(1);
      period_end <= (cnt == CNT_PRE);
    end
  end

  // Extra MSB lets duty == 2^CNT_W compare as always-high.
  assign pwm_out = ({1'b0, cnt} < duty);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Breathing/fade sequencer: ramps the PWM duty up to full scale, dwells,
// ramps down to zero, dwells, and repeats while en is high. Dropping en
// always fades down to zero before parking in IDLE. Duty, hold counter and
// state only change at the period boundary, so every period is whole.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : 1 = run breathing cycle, 0 = fade out and park
//   step         : duty change per period (0 behaves as 1)
//   hold_periods : extra periods to dwell at full scale and at zero
//   pwm_out      : PWM output
//   duty         : current active duty, 0..2^CNT_W
//   period_end   : one-cycle pulse while cnt == 2^CNT_W-1
//   state        : FSM state encoding for debug/LEDs
module pwm_fade_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W  = 12,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned HOLD_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [STEP_W-1:0]  step,
  input  logic [HOLD_W-1:0]  hold_periods,
  output logic               pwm_out,
  output logic [CNT_W:0]     duty,
  output logic               period_end,
  output logic [STATE_W-1:0] state
);

  localparam int unsigned DW     = CNT_W + 1;
  localparam int unsigned AW     = CNT_W + 2;
  localparam int unsigned DMAX_I = dmax(CNT_W);
  localparam logic [AW-1:0] DMAX_A = AW'(DMAX_I);
  localparam logic [DW-1:0] DMAX_D = DW'(DMAX_I);

  fade_state_e       state_q, state_nxt;
  logic [DW-1:0]     duty_q, duty_nxt;
  logic [HOLD_W-1:0] hold_q, hold_nxt;

  logic [AW-1:0] step_a;
  logic [AW-1:0] up_a;
  logic [AW-1:0] down_a;
  logic [DW-1:0] duty_up;
  logic [DW-1:0] duty_dn;

  pwm_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .duty       (duty_q),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  // Saturating up/down duty arithmetic; step is clamped to full scale first
  // so a wide step input cannot overflow the narrow arithmetic width.
  always_comb begin
    step_a = AW'(1);
    if (step == '0) begin
      step_a = AW'(1);
    end else if (32'(step) >= DMAX_I) begin
      step_a = DMAX_A;
    end else begin
      step_a = AW'(step);
    end

    up_a = AW'(duty_q) + step_a;
    if (up_a > DMAX_A) begin
      up_a = DMAX_A;
    end

    down_a = '0;
    if (AW'(duty_q) > step_a) begin
      down_a = AW'(duty_q) - step_a;
    end

    duty_up = DW'(up_a);
    duty_dn = DW'(down_a);
  end

  // State, duty and hold registers; period_end marks the boundary edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      duty_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      duty_q  <= duty_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // Next-state logic; everything holds between period boundaries.
  always_comb begin
    state_nxt = state_q;
    duty_nxt  = duty_q;
    hold_nxt  = hold_q;

    if (period_end) begin
      case (state_q)
        IDLE: begin
          if (en) begin
            duty_nxt  = duty_up;
            state_nxt = UP;
          end else begin
            duty_nxt  = '0;
          end
        end

        UP: begin
          if (!en) begin
            state_nxt = DOWN;
            duty_nxt  = duty_dn;
          end else begin
            duty_nxt = duty_up;
            if (duty_up == DMAX_D) begin
              state_nxt = HOLD_HI;
              hold_nxt  = hold_periods;
            end
          end
        end

        HOLD_HI: begin
          if (!en || (hold_q == '0)) begin
            state_nxt = DOWN;
            duty_nxt  = duty_dn;
          end else begin
            hold_nxt = hold_q - HOLD_W'(1);
          end
        end

        // A rising en does not reverse a fade-out; it only picks HOLD_LO.
        DOWN: begin
          duty_nxt = duty_dn;
          if (duty_dn == '0) begin
            if (!en) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = HOLD_LO;
              hold_nxt  = hold_periods;
            end
          end
        end

        HOLD_LO: begin
          if (!en) begin
            state_nxt = IDLE;
          end else if (hold_q == '0) begin
            state_nxt = UP;
            duty_nxt  = duty_up;
          end else begin
            hold_nxt = hold_q - HOLD_W'(1);
          end
        end

        default: begin
          state_nxt = IDLE;
          duty_nxt  = '0;
          hold_nxt  = '0;
        end
      endcase
    end
  end

  assign duty  = duty_q;
  assign state = state_q;

endmodule

// File: doc/pwm_fade_ctrl.md
Name: pwm_fade_ctrl

Overview:
Breathing/fade sequencer for the board LED PWM outputs. It owns a free-running PWM period counter and a runtime duty register. A small FSM ramps the duty up and down, with programmable step and hold times, so LEDs fade smoothly instead of running at a fixed compile-time percentage. Duty changes only at PWM period boundaries, so there are no partial or glitched periods.

Parameters:
CNT_W, 12, PWM counter width; period = 2^CNT_W clocks; full-scale duty DMAX = 2^CNT_W.
STEP_W, 8, width of step input.
HOLD_W, 8, width of hold_periods input.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
en  in  1  level; 1 = run breathing cycle, 0 = fade out and park
step  in  STEP_W  duty increment/decrement applied per period; 0 treated as 1
hold_periods  in  HOLD_W  extra periods to dwell at DMAX and at 0
pwm_out  out  1  PWM output, (cnt < duty)
duty  out  CNT_W+1  current active duty, 0..DMAX
period_end  out  1  one-cycle pulse, high while cnt == 2^CNT_W-1
state  out  3  FSM state encoding, for debug/LEDs

Behaviour:
- Reset values (async, immediate): cnt=0, duty=0, hold_cnt=0, state=IDLE, pwm_out=0, period_end=0. Reset mid-ramp returns to these values. The first period after release starts at cnt=0.
- cnt increments every clk and wraps from 2^CNT_W-1 to 0.
- pwm_out = (cnt < duty), computed combinationally from registers.
  - duty=0 gives constant 0.
  - duty=DMAX gives constant 1.
- Boundary B is the clk edge at which cnt == 2^CNT_W-1. All FSM, duty and hold_cnt updates occur only at B; between boundaries they are frozen. A new duty takes effect from cnt=0.
- step and hold_periods are sampled only at B. s = (step==0) ? 1 : step.
- Duty arithmetic is done at CNT_W+2 bits. Up: min(duty+s, DMAX). Down: max(duty-s, 0). Never wraps.
- FSM transitions at B:
  - IDLE: if en=1, duty<=up(duty), state<=UP; else hold duty=0.
  - UP: if en=0, state<=DOWN, duty<=down(duty). Else duty<=up(duty); if the result equals DMAX, state<=HOLD_HI and hold_cnt<=hold_periods.
  - HOLD_HI: if en=0, state<=DOWN, duty<=down(duty). Else if hold_cnt==0, state<=DOWN, duty<=down(duty). Else hold_cnt--.
  - DOWN: duty<=down(duty). If the result is 0: state<=IDLE when en=0, otherwise state<=HOLD_LO with hold_cnt<=hold_periods.
  - HOLD_LO: if en=0, state<=IDLE. Else if hold_cnt==0, state<=UP, duty<=up(duty). Else hold_cnt--.
- Dwell: duty sits at DMAX for hold_periods+1 periods, and likewise at 0.
- Dropping en never cuts duty abruptly. The block always fades down to 0 before IDLE.
- Raising en during a DOWN fade-out does not reverse direction. The fade continues to 0, then goes to HOLD_LO.
- period_end is registered: high exactly one clk per period, aligned with cnt == 2^CNT_W-1.

Decomposition:
- Shared package pwm_pkg holds:
  - state encodings IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4;
  - the DMAX function of CNT_W.
- One natural sub-module: pwm_core (CNT_W). Contains the counter, period_end and the compare against a duty input. pwm_fade_ctrl instantiates pwm_core plus the FSM and duty/hold registers.

Test Plan:
- CNT_W=4, en=1, step=4, hold=1, from reset: per-period duty 4,8,12,16,16,12,8,4,0,0,4 -> state UP…HOLD_HI…DOWN…HOLD_LO…UP; pwm_out high 4 of 16 clks when duty=4, constant high at 16.
- CNT_W=4, step=5, hold=0: duty 5,10,15,16,11,6,1,0,5 -> saturation at 16 and 0, no wrap.
- CNT_W=4, step=0: duty increases by 1 per period (1,2,3…) -> step=0 never stalls.
- CNT_W=4, step=4, hold=3: drop en at duty=8 in UP -> next periods 4,0, then IDLE with duty=0 and pwm_out=0 indefinitely; re-raise en -> restarts at 4.
- Assert rst asynchronously mid-HOLD_HI (not clk-aligned) -> duty=0, pwm_out=0, state=IDLE immediately; after release first period_end at clk 16.
- Change step from 2 to 8 mid-period -> ramp applies the new value only at the next boundary; duty never changes while cnt != 2^CNT_W-1.
